// File: rtl/buzzer_arbiter.sv
// Three-requester priority arbiter driving a single square-wave buzzer output.
// Optional BUZZER_ARBITER_SIREN_EN replaces requester 2's divider with an internal sweep.
module buzzer_arbiter #(
  parameter int unsigned MIN_HOLD = 2000000,
  parameter int unsigned GAP      = 16000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  REQ,
  input  logic [14:0] DIV0,
  input  logic [14:0] DIV1,
  input  logic [14:0] DIV2,
  output logic [2:0]  GNT,
  output logic        BUZZ,
  output logic        BUSY
);

  localparam int unsigned DIV_W  = 15;
  localparam int unsigned HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DIV_W-1:0]   tone_q, tone_d;
  logic [2:0]         gnt_q, gnt_d;
  logic               buzz_q, buzz_d;
  logic               busy_q, busy_d;

  logic [DIV_W-1:0]   div2_src;
  logic [1:0]         new_idx;
  logic [2:0]         new_oh;
  logic [DIV_W-1:0]   new_div;
  logic [2:0]         owner_oh;
  logic [DIV_W-1:0]   live_div;
  logic               owner_req;
  logic [2:0]         others;
  logic [2:0]         higher;
  logic               hold_sat;

`ifdef BUZZER_ARBITER_SIREN_EN
  // Free-running sweep gives requester 2 a rising/falling siren pitch.
  logic [21:0] sweep_q, sweep_d;
  logic [6:0]  ramp;
  logic        unused_div2;

  always_comb sweep_d = sweep_q + 22'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sweep_q <= '0;
    else        sweep_q <= sweep_d;
  end

  assign ramp        = sweep_q[21] ? sweep_q[20:14] : ~sweep_q[20:14];
  assign div2_src    = {3'b001, ramp, 5'b00000};
  assign unused_div2 = ^DIV2;
`else
  assign div2_src = DIV2;
`endif

  function automatic logic [2:0] to_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    to_onehot = 3'b001;
      2'd1:    to_onehot = 3'b010;
      default: to_onehot = 3'b100;
    endcase
  endfunction

  function automatic logic [14:0] div_sel(input logic [1:0] idx, input logic [14:0] d0,
                                          input logic [14:0] d1, input logic [14:0] d2);
    case (idx)
      2'd0:    div_sel = d0;
      2'd1:    div_sel = d1;
      default: div_sel = d2;
    endcase
  endfunction

  // Priority pick and owner-relative request views.
  always_comb begin
    if (REQ[0])      new_idx = 2'd0;
    else if (REQ[1]) new_idx = 2'd1;
    else             new_idx = 2'd2;
    new_oh    = to_onehot(new_idx);
    new_div   = div_sel(new_idx, DIV0, DIV1, div2_src);
    owner_oh  = to_onehot(owner_q);
    live_div  = div_sel(owner_q, DIV0, DIV1, div2_src);
    owner_req = |(REQ & owner_oh);
    others    = REQ & ~owner_oh;
    higher    = REQ & 3'(owner_oh - 3'd1);
    hold_sat  = (hold_q >= HOLD_W'(MIN_HOLD - 1));
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    tone_d  = tone_q;
    gnt_d   = 3'b000;
    buzz_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          state_d = S_PLAY;
          owner_d = new_idx;
          hold_d  = '0;
          tone_d  = new_div;
          gnt_d   = new_oh;
        end
      end
      S_PLAY: begin
        if (!owner_req || ((|higher) && hold_sat)) begin
          state_d = (!owner_req && !(|others)) ? S_IDLE : S_GAP;
          gap_d   = '0;
          hold_d  = '0;
          tone_d  = '0;
        end else begin
          gnt_d = gnt_q;
          if (!hold_sat) hold_d = hold_q + HOLD_W'(1);
          // Divider is sampled live only at reload so mid-tone changes never restart the count.
          if (tone_q == '0) begin
            tone_d = live_div;
            buzz_d = (live_div == '0) ? 1'b0 : ~buzz_q;
          end else begin
            tone_d = tone_q - DIV_W'(1);
            buzz_d = buzz_q;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          gap_d = '0;
          if (|REQ) begin
            state_d = S_PLAY;
            owner_d = new_idx;
            hold_d  = '0;
            tone_d  = new_div;
            gnt_d   = new_oh;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      hold_q  <= '0;
      gap_q   <= '0;
      tone_q  <= '0;
      gnt_q   <= 3'b000;
      buzz_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      tone_q  <= tone_d;
      gnt_q   <= gnt_d;
      buzz_q  <= buzz_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign BUZZ = buzz_q;
  assign BUSY = busy_q;

endmodule
